// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that drives a shared output mux.
// An idle cycle always separates two grants. Each grant lasts until one of:
//   - a transfer carries last,
//   - MAX_HOLD transfers have completed,
//   - the granted requester drops its request.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req, last        per-requester valid and end-of-burst flag
//   inp              requester data, slice i = inp[i*DATA_W +: DATA_W]
//   out_ready        downstream ready
//   gnt, sel         registered one-hot grant and its index
//   out_valid, out   downstream valid and muxed data (zero when not valid)
//   busy             high while a grant is held

// One mux lane: forwards its data only when enabled, so the output is an OR of lanes.
module rr_mux_lane #(
  parameter int DATA_W = 1
) (
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);
  assign q_o = en_i ? d_i : '0;
endmodule

module rr_mux_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SEL_NUM  = $clog2(NUM_REQ),
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        last,
  input  logic [NUM_REQ*DATA_W-1:0] inp,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_NUM-1:0]        sel,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out,
  output logic                      busy
);
  localparam int CNT_W = $clog2(MAX_HOLD+1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_NUM-1:0]   sel_q, sel_d;
  logic [SEL_NUM-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_NUM-1:0]   pick, pick_hi, pick_lo;
  logic                 hit_hi;
  logic                 xfer, rel;
  logic [NUM_REQ-1:0][DATA_W-1:0] lane_q;

  // Rotating priority starting at ptr.
  // pick_hi is the lowest requester at or above ptr.
  // pick_lo is the lowest requester overall and is used when the scan wraps.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hit_hi  = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[i]) pick_lo = SEL_NUM'(i);
      if (req[i] && (SEL_NUM'(i) >= ptr_q)) begin
        pick_hi = SEL_NUM'(i);
        hit_hi  = 1'b1;
      end
    end
    pick = hit_hi ? pick_hi : pick_lo;
  end

  assign out_valid = (state_q == GRANT) && req[sel_q];
  assign xfer      = out_valid && out_ready;
  // A dropped request releases even though no transfer happens in that cycle.
  assign rel       = (xfer && (last[sel_q] || ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_HOLD))))
                   || !req[sel_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << pick;
          sel_d   = pick;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (sel_q == SEL_NUM'(NUM_REQ-1)) ? '0 : sel_q + 1'b1;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // gnt_q is one-hot in GRANT and zero otherwise, so at most one lane is enabled.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    rr_mux_lane #(.DATA_W(DATA_W)) u_lane (
      .en_i (gnt_q[g] & out_valid),
      .d_i  (inp[g*DATA_W +: DATA_W]),
      .q_o  (lane_q[g])
    );
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < NUM_REQ; i++) out = out | lane_q[i];
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q == GRANT);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and random checks for rr_mux_arbiter.
// Configuration: 4 requesters, 8-bit data, MAX_HOLD = 8.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int DW = 8;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, last;
  logic [N*DW-1:0] inp;
  logic          out_ready;
  logic [N-1:0]  gnt;
  logic [SW-1:0] sel;
  logic          out_valid;
  logic [DW-1:0] out;
  logic          busy;

  int tests = 0;
  int fails = 0;

  rr_mux_arbiter #(.NUM_REQ(N), .SEL_NUM(SW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .inp(inp),
    .out_ready(out_ready), .gnt(gnt), .sel(sel), .out_valid(out_valid),
    .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts transfers of the current grant until it releases (bounded).
  task automatic count_xfers(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy && out_valid && out_ready) n++;
      step();
      if (!busy) break;
    end
  endtask

  int n;
  int waitc [N];
  int viol_oh, viol_st, viol_busy, grants;
  logic [N-1:0] prev_g;

  initial begin
    rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b1; inp = 32'hA3A2A1A0;
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out", out, 0);
    rst_n = 1'b1;

    // Rotating priority from 0: requesters 1 and 3 pending.
    req = 4'b1010;
    #1 check("latency_gnt", gnt, 0);
    step();
    check("a_gnt1", gnt, 4'b0010);
    check("a_sel1", sel, 1);
    check("a_busy", busy, 1);
    check("a_out", out, 8'hA1);
    last = 4'b0010;
    step();
    check("a_rel_busy", busy, 0);
    check("a_idle_valid", out_valid, 0);
    check("a_idle_sel", sel, 1);
    last = '0;
    step();
    check("a_gnt3", gnt, 4'b1000);
    check("a_sel3", sel, 3);
    check("a_out3", out, 8'hA3);
    req = '0;
    #1 check("a_drop_valid", out_valid, 0);
    step();
    check("a_drop_rel", busy, 0);
    step();
    check("idle_gnt", gnt, 0);
    check("idle_sel_hold", sel, 3);

    // Hold limit with one requester.
    req = 4'b0001;
    step();
    check("b_gnt0", gnt, 4'b0001);
    count_xfers(n);
    check("b_xfers", n, MH);
    check("b_idle_valid", out_valid, 0);
    check("b_idle_gnt", gnt, 0);
    step();
    check("b_regrant", gnt, 4'b0001);

    // Backpressure on requester 2.
    req = '0;
    step();
    check("c_rel", busy, 0);
    req = 4'b0100;
    step();
    check("c_gnt2", gnt, 4'b0100);
    step(); step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("c_stall_gnt", gnt, 4'b0100);
      check("c_stall_valid", out_valid, 1);
      check("c_stall_out", out, 8'hA2);
    end
    out_ready = 1'b1;
    count_xfers(n);
    check("c_resume_xfers", n, MH - 2);

    // Last on third transfer of requester 1.
    req = 4'b0010;
    step();
    check("d_gnt1", gnt, 4'b0010);
    step(); step();
    check("d_busy2", busy, 1);
    last = 4'b0010;
    step();
    check("d_last_rel", busy, 0);
    last = '0;
    req = 4'b0110;
    step();
    check("d_ptr2", gnt, 4'b0100);
    req = '0;
    step();
    req = 4'b0010;
    step();
    check("d_gnt1b", gnt, 4'b0010);
    step();
    req = '0;
    #1 check("d_drop_valid", out_valid, 0);
    step();
    check("d_drop_rel", busy, 0);
    req = 4'b0010;
    step();
    count_xfers(n);
    check("d_cnt_cleared", n, MH);

    // Asynchronous reset mid-grant.
    step();
    check("e_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("e_gnt", gnt, 0);
    check("e_valid", out_valid, 0);
    check("e_busy0", busy, 0);
    check("e_sel", sel, 0);
    step();
    rst_n = 1'b1;
    req = 4'b1111;
    step();
    check("e_first_gnt", gnt, 4'b0001);
    check("e_first_sel", sel, 0);

    // Random traffic: one-hot grants and bounded waiting.
    viol_oh = 0; viol_st = 0; viol_busy = 0; grants = 0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    prev_g = gnt;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      last      = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      out_ready = ($urandom_range(3) != 0);
      inp       = $urandom;
      for (int i = 0; i < N; i++) if (!req[i]) waitc[i] = 0;
      step();
      if ((gnt & (gnt - 1'b1)) != 0) viol_oh++;
      if (busy != (gnt != 0)) viol_busy++;
      if (gnt != 0 && prev_g == 0) begin
        grants++;
        for (int i = 0; i < N; i++) begin
          if (gnt[i]) waitc[i] = 0;
          else if (req[i]) begin
            waitc[i]++;
            if (waitc[i] > N) viol_st++;
          end
        end
      end
      prev_g = gnt;
    end
    check("f_onehot", viol_oh, 0);
    check("f_busy", viol_busy, 0);
    check("f_starve", viol_st, 0);
    check("f_activity", grants > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
